// File: rtl/sound_scheduler.sv
// Shares one sound generator between bad-collision, good-collision and direction events.
// Requests are latched, granted one at a time by fixed priority, and played as timed tones.
module sound_scheduler #(
  parameter int DUR_GOOD = 25,
  parameter int DUR_BAD  = 50,
  parameter int DUR_DIR  = 5,
  parameter int GAP_CYC  = 2,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       nRst_i,
  input  logic       button_i,
  input  logic       goodColl_i,
  input  logic       badColl_i,
  input  logic [3:0] direction_i,
  output logic       playSound,
  output logic [1:0] tone_o,
  output logic       mode_o,
  output logic       busy_o
);

  // state | meaning
  // IDLE  | nothing playing, waiting for a pending request
  // PLAY  | generator enabled, counting down the tone duration
  // GAP   | enforced silence between consecutive tones
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  localparam logic [1:0] TONE_NONE = 2'b00;
  localparam logic [1:0] TONE_GOOD = 2'b01;
  localparam logic [1:0] TONE_BAD  = 2'b10;
  localparam logic [1:0] TONE_DIR  = 2'b11;

  localparam logic [CNT_W-1:0] LD_GOOD = CNT_W'(DUR_GOOD - 1);
  localparam logic [CNT_W-1:0] LD_BAD  = CNT_W'(DUR_BAD - 1);
  localparam logic [CNT_W-1:0] LD_DIR  = CNT_W'(DUR_DIR - 1);
  localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'(GAP_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_btn_prev, r_good_prev, r_bad_prev;
  logic [3:0]       r_dir_prev;
  logic             r_pend_good, r_pend_bad, r_pend_dir;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_play_nxt;
  logic [1:0]       w_tone_nxt;
  logic             w_grant;
  logic             w_clr_good, w_clr_bad, w_clr_dir;

  logic w_btn_rise, w_good_ev, w_bad_ev, w_dir_ev, w_active, w_any_pend;

  assign w_btn_rise = button_i & ~r_btn_prev;
  assign w_good_ev  = goodColl_i & ~r_good_prev;
  assign w_bad_ev   = badColl_i & ~r_bad_prev;
  assign w_dir_ev   = (direction_i != 4'b0000) && (direction_i != r_dir_prev);
  // The edge that turns the mode off already behaves as OFF
  assign w_active   = mode_o & ~w_btn_rise;
  assign w_any_pend = r_pend_good | r_pend_bad | r_pend_dir;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_play_nxt  = playSound;
    w_tone_nxt  = tone_o;
    w_grant     = 1'b0;
    w_clr_good  = 1'b0;
    w_clr_bad   = 1'b0;
    w_clr_dir   = 1'b0;
    if (!w_active) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_play_nxt  = 1'b0;
      w_tone_nxt  = TONE_NONE;
    end else begin
      case (r_state)
        S_IDLE: w_grant = w_any_pend;
        S_PLAY: begin
          if ((tone_o != TONE_BAD) && r_pend_bad) begin
            w_grant = 1'b1;
          end else if (r_cnt == '0) begin
            w_state_nxt = S_GAP;
            w_play_nxt  = 1'b0;
            w_tone_nxt  = TONE_NONE;
            w_cnt_nxt   = LD_GAP;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == '0) begin
            if (w_any_pend) w_grant = 1'b1;
            else            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
      if (w_grant) begin
        w_state_nxt = S_PLAY;
        w_play_nxt  = 1'b1;
        if (r_pend_bad) begin
          w_clr_bad  = 1'b1;
          w_tone_nxt = TONE_BAD;
          w_cnt_nxt  = LD_BAD;
        end else if (r_pend_good) begin
          w_clr_good = 1'b1;
          w_tone_nxt = TONE_GOOD;
          w_cnt_nxt  = LD_GOOD;
        end else begin
          w_clr_dir  = 1'b1;
          w_tone_nxt = TONE_DIR;
          w_cnt_nxt  = LD_DIR;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_btn_prev  <= 1'b0;
      r_good_prev <= 1'b0;
      r_bad_prev  <= 1'b0;
      r_dir_prev  <= 4'b0000;
      r_pend_good <= 1'b0;
      r_pend_bad  <= 1'b0;
      r_pend_dir  <= 1'b0;
      playSound   <= 1'b0;
      tone_o      <= TONE_NONE;
      mode_o      <= 1'b1;
      busy_o      <= 1'b0;
    end else begin
      r_btn_prev  <= button_i;
      r_good_prev <= goodColl_i;
      r_bad_prev  <= badColl_i;
      r_dir_prev  <= direction_i;
      mode_o      <= mode_o ^ w_btn_rise;
      // A new event on the grant edge re-arms the request it just consumed
      r_pend_good <= w_active & ((r_pend_good & ~w_clr_good) | w_good_ev);
      r_pend_bad  <= w_active & ((r_pend_bad  & ~w_clr_bad)  | w_bad_ev);
      r_pend_dir  <= w_active & ((r_pend_dir  & ~w_clr_dir)  | w_dir_ev);
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      playSound   <= w_play_nxt;
      tone_o      <= w_tone_nxt;
      busy_o      <= (w_state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler: directed scenarios plus random events, every cycle
// compared against a tone-queue model built from remaining-cycle counts.
module tb_sound_scheduler;
  localparam int DG = 25, DB = 50, DD = 5, GP = 2;

  logic       clk = 1'b0;
  logic       nRst_i = 1'b1;
  logic       button_i = 1'b0, goodColl_i = 1'b0, badColl_i = 1'b0;
  logic [3:0] direction_i = 4'b0000;
  logic       playSound, mode_o, busy_o;
  logic [1:0] tone_o;

  always #5 clk = ~clk;

  sound_scheduler #(.DUR_GOOD(DG), .DUR_BAD(DB), .DUR_DIR(DD), .GAP_CYC(GP), .CNT_W(8)) dut (
    .clk(clk), .nRst_i(nRst_i), .button_i(button_i), .goodColl_i(goodColl_i),
    .badColl_i(badColl_i), .direction_i(direction_i), .playSound(playSound),
    .tone_o(tone_o), .mode_o(mode_o), .busy_o(busy_o)
  );

  int n_checks = 0, n_errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a tone is "play_left" cycles of sound followed by "gap_left" silent cycles
  int         m_play_left = 0, m_gap_left = 0, m_tone = 0;
  bit         m_mode = 1'b1, pend_b = 1'b0, pend_g = 1'b0, pend_d = 1'b0;
  bit         p_btn = 1'b0, p_good = 1'b0, p_bad = 1'b0;
  logic [3:0] p_dir = 4'b0000;

  task automatic m_start();
    if (pend_b) begin
      pend_b = 1'b0; m_tone = 2; m_play_left = DB;
    end else if (pend_g) begin
      pend_g = 1'b0; m_tone = 1; m_play_left = DG;
    end else begin
      pend_d = 1'b0; m_tone = 3; m_play_left = DD;
    end
    m_gap_left = 0;
  endtask

  always @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      m_play_left = 0; m_gap_left = 0; m_tone = 0; m_mode = 1'b1;
      pend_b = 1'b0; pend_g = 1'b0; pend_d = 1'b0;
      p_btn = 1'b0; p_good = 1'b0; p_bad = 1'b0; p_dir = 4'b0000;
    end else begin
      bit ev_g, ev_b, ev_d, btn, active;
      ev_g   = goodColl_i && !p_good;
      ev_b   = badColl_i && !p_bad;
      ev_d   = (direction_i != 4'b0000) && (direction_i != p_dir);
      btn    = button_i && !p_btn;
      active = m_mode && !btn;
      if (btn) m_mode = !m_mode;
      if (!active) begin
        m_play_left = 0; m_gap_left = 0;
        pend_b = 1'b0; pend_g = 1'b0; pend_d = 1'b0;
      end else begin
        if (m_play_left > 0) begin
          if (m_tone != 2 && pend_b) m_start();
          else begin
            m_play_left--;
            if (m_play_left == 0) m_gap_left = GP;
          end
        end else if (m_gap_left > 0) begin
          m_gap_left--;
          if (m_gap_left == 0 && (pend_b || pend_g || pend_d)) m_start();
        end else if (pend_b || pend_g || pend_d) begin
          m_start();
        end
        pend_b = pend_b | ev_b;
        pend_g = pend_g | ev_g;
        pend_d = pend_d | ev_d;
      end
      p_btn = button_i; p_good = goodColl_i; p_bad = badColl_i; p_dir = direction_i;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("play", playSound, (m_play_left > 0) ? 1 : 0);
      chk("tone", tone_o, (m_play_left > 0) ? m_tone : 0);
      chk("busy", busy_o, (m_play_left > 0 || m_gap_left > 0) ? 1 : 0);
      chk("mode", mode_o, m_mode);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_btn();
    @(negedge clk) button_i = 1'b1;
    @(negedge clk) button_i = 1'b0;
  endtask

  initial begin
    #1 nRst_i = 1'b0;
    #1;
    chk("rst0_play", playSound, 0);
    chk("rst0_tone", tone_o, 0);
    chk("rst0_mode", mode_o, 1);
    chk_en = 1'b1;
    idle(2);
    nRst_i = 1'b1;
    idle(3);

    // single good tone
    @(negedge clk) goodColl_i = 1'b1;
    @(negedge clk) goodColl_i = 1'b0;
    idle(35);

    // good and direction together, good held high for 10 cycles
    @(negedge clk) begin goodColl_i = 1'b1; direction_i = 4'b0001; end
    idle(10);
    goodColl_i = 1'b0;
    idle(45);

    // bad preempts a running good tone
    @(negedge clk) goodColl_i = 1'b1;
    @(negedge clk) goodColl_i = 1'b0;
    idle(9);
    badColl_i = 1'b1;
    @(negedge clk) badColl_i = 1'b0;
    idle(70);

    // mode OFF during a bad tone, events ignored, then back ON without replay
    @(negedge clk) badColl_i = 1'b1;
    @(negedge clk) badColl_i = 1'b0;
    idle(10);
    pulse_btn();
    idle(3);
    goodColl_i = 1'b1; badColl_i = 1'b1; direction_i = 4'b0100;
    idle(2);
    goodColl_i = 1'b0; badColl_i = 1'b0;
    idle(5);
    pulse_btn();
    idle(20);

    // direction edges: repeat is no event, change is an event, zero is no event
    direction_i = 4'b0001;
    idle(15);
    idle(10);
    direction_i = 4'b0100;
    idle(15);
    direction_i = 4'b0000;
    idle(15);

    // asynchronous reset in the middle of a tone
    @(negedge clk) goodColl_i = 1'b1;
    @(negedge clk) goodColl_i = 1'b0;
    idle(5);
    @(posedge clk);
    #2 nRst_i = 1'b0;
    #1;
    chk("rst1_play", playSound, 0);
    chk("rst1_tone", tone_o, 0);
    chk("rst1_mode", mode_o, 1);
    chk("rst1_busy", busy_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) nRst_i = 1'b1;
    idle(5);

    // random event traffic
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) goodColl_i = ~goodColl_i;
      if ($urandom_range(0, 59) == 0) badColl_i = ~badColl_i;
      if ($urandom_range(0, 399) == 0) button_i = ~button_i;
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 4))
          0: direction_i = 4'b0000;
          1: direction_i = 4'b0001;
          2: direction_i = 4'b0010;
          3: direction_i = 4'b0100;
          default: direction_i = 4'b1000;
        endcase
      end
    end
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sound_scheduler.md
Name: sound_scheduler

Overview:
- Arbitrates the single shared sound generator among three game event sources: good collision, bad collision and direction change.
- Latches each request, grants one at a time by fixed priority, and drives the generator with a tone select and a timed play enable.
- Owns the user sound mode (ON/OFF), which the button toggles.
- Sits between the game-logic event outputs and the sound generator tone/enable inputs.

Parameters:
- DUR_GOOD, 25, playSound high cycles for a good-collision tone (≥1)
- DUR_BAD, 50, playSound high cycles for a bad-collision tone (≥1)
- DUR_DIR, 5, playSound high cycles for a direction-change tick (≥1)
- GAP_CYC, 2, silent cycles enforced between consecutive tones (≥1)
- CNT_W, 8, duration/gap counter width; every DUR_* and GAP_CYC must be < 2^CNT_W

Ports:
- clk, input, 1, system clock
- nRst_i, input, 1, reset; asynchronous, active-low
- button_i, input, 1, mode button, level; rising edge toggles mode
- goodColl_i, input, 1, good collision, level; rising edge is a request
- badColl_i, input, 1, bad collision, level; rising edge is a request
- direction_i, input, 4, one-hot snake direction; 0 means no direction
- playSound, output, 1, generator enable
- tone_o, output, 2, tone select: 00 none, 01 good, 10 bad, 11 dir
- mode_o, output, 1, sound mode: 1 ON, 0 OFF
- busy_o, output, 1, high in PLAY or GAP

Behaviour:
- Reset values:
  - Outputs: playSound=0, tone_o=00, mode_o=1 (ON), busy_o=0.
  - State: FSM=IDLE, all pending bits=0, counter=0.
  - Edge-detect registers: previous button/goodColl/badColl=0, previous direction=0.
- Reset assertion mid-tone forces all of the above immediately, asynchronously.
- All outputs are registered.
- Event detection, sampled at posedge:
  - Good and bad requests are rising edges, i.e. input=1 and previous=0.
  - A direction event is direction_i≠0 and direction_i≠previous direction.
  - Each detected event sets its pending bit at that same edge.
  - Repeated events of one type while pending coalesce into a single request.
- If an event and the grant of the same type occur on one edge, the set wins and the request stays pending.
- Mode:
  - A button rising edge toggles mode_o at that edge.
  - While mode_o=0, or on the edge where mode switches to OFF: all pending bits clear, new events are ignored, and FSM goes to IDLE with playSound=0, tone_o=00.
  - Switching back to ON does not replay any discarded events.
- Priority: BAD > GOOD > DIR.
- FSM states: IDLE, PLAY, GAP.
  - IDLE→PLAY: when any pending bit is set. Grant the highest pending request, clear its pending bit, set tone_o, set playSound=1, load counter=DUR_x−1.
  - PLAY: counter decrements each cycle. At counter=0, go PLAY→GAP with playSound=0, tone_o=00, counter=GAP_CYC−1.
  - Preemption in PLAY: if tone_o≠10 and pending_bad=1, the next edge reloads with the BAD tone and counter=DUR_BAD−1, and playSound stays 1. The preempted tone is dropped. GOOD and DIR never preempt.
  - GAP: counter decrements. At counter=0, go to PLAY with a new grant if anything is pending, else to IDLE.
- Latency and tone length:
  - A request edge at posedge k gives playSound=1 after posedge k+1.
  - playSound stays high for exactly DUR_x cycles, then stays low for exactly GAP_CYC cycles.
- busy_o=1 in PLAY and GAP.

Test Plan:
- Reset and idle: assert nRst_i=0 mid-cycle → immediately playSound=0, tone_o=00, mode_o=1. Hold reset for 2 clocks, release → outputs unchanged and no tone.
- Single good request: one-cycle goodColl_i pulse at edge k → playSound=1 and tone_o=01 from edge k+1 for exactly 25 cycles, then 2 cycles silent with busy_o=1, then busy_o=0.
- Priority: goodColl_i and direction_i=0001 on the same edge → tone 01 for 25 cycles, 2-cycle gap, tone 11 for 5 cycles. Holding goodColl_i high for 10 cycles produces only one good tone.
- Preemption: badColl_i rises 10 cycles into a good tone → next edge tone_o=10 with playSound unbroken for 50 cycles. The good tone does not resume.
- Mode OFF: button pulse during a bad tone → mode_o=0 and playSound=0 next edge. goodColl_i/badColl_i/direction edges while OFF → no tone. A second button pulse → mode_o=1 with no replay.
- Direction edges: direction_i 0001→0001 gives no event; 0001→0100 gives tone 11; →0000 gives no event.
